// File: rtl/b_uart_pkg.sv
// Shared definitions for the b_uart transceiver: 8N1 frame constants,
// RX/TX state encodings and the baud divider calculation.
package b_uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = DATA_BITS + 2;  // start + data + stop

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_FERR    // stop bit was low: hold off until the line returns high
  } rx_state_t;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_t;

  // Clock cycles per serial bit; integer division, caller guarantees >= 4.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/b_uart_inpin.sv
// Two-flop synchronizer for an asynchronous input pin.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset, forces both flops to the idle-line level (1)
//   pin  asynchronous input
//   rd   synchronized, registered copy of pin (2 cycles latency)
module inpin (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic rd
);

  logic meta;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values; blocking here would collapse the two stages into one.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      rd   <= 1'b1;
    end else begin
      meta <= pin;
      rd   <= meta;
    end
  end

endmodule

// File: rtl/b_uart.sv
// Byte-wide 8N1 UART transceiver, LSB first, fixed baud, full duplex.
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   rx       serial input (asynchronous)
//   tx       serial output, idle high
//   rd       pulse: consume the received byte (clears valid)
//   wr       pulse: start sending tx_data (ignored while busy)
//   tx_data  byte to send, captured on an accepted wr
//   valid    rx_data holds an unconsumed byte
//   busy     transmitter occupied
//   rx_data  last received byte
module b_uart
  import b_uart_pkg::*;
#(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 115200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 rd,
  input  logic                 wr,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 valid,
  output logic                 busy,
  output logic [DATA_BITS-1:0] rx_data
);

  localparam int CPB   = clks_per_bit(CLK_HZ, BAUD);
  localparam int CNT_W = $clog2(CPB) + 1;
  typedef logic [CNT_W-1:0] cnt_t;

  // Counters run down to zero, so a full bit is CPB-1 and the first
  // mid-bit point after the start edge is CPB/2-1.
  localparam cnt_t CNT_FULL = cnt_t'(CPB - 1);
  localparam cnt_t CNT_HALF = cnt_t'(CPB / 2 - 1);
  localparam logic [2:0] LAST_RX_BIT = 3'(DATA_BITS - 1);
  localparam logic [3:0] LAST_TX_BIT = 4'(FRAME_BITS - 1);

  logic rx_s;

  inpin u_inpin (
    .clk (clk),
    .rst (rst),
    .pin (rx),
    .rd  (rx_s)
  );

  // ---------------- receiver ----------------
  rx_state_t            rx_state, rx_state_d;
  cnt_t                 rx_cnt, rx_cnt_d;
  logic [2:0]           rx_bit, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_d;
  logic [DATA_BITS-1:0] rx_data_d;
  logic                 valid_d;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt;
    rx_bit_d   = rx_bit;
    rx_sh_d    = rx_sh;
    rx_data_d  = rx_data;
    valid_d    = valid;

    if (rd) valid_d = 1'b0;

    unique case (rx_state)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_state_d = RX_START;
          rx_cnt_d   = CNT_HALF;
        end
      end
      RX_START: begin
        if (rx_cnt == '0) begin
          if (rx_s) begin
            rx_state_d = RX_IDLE;   // too short to be a start bit
          end else begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = CNT_FULL;
            rx_bit_d   = '0;
          end
        end else begin
          rx_cnt_d = rx_cnt - 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt == '0) begin
          rx_sh_d  = {rx_s, rx_sh[DATA_BITS-1:1]};
          rx_cnt_d = CNT_FULL;
          if (rx_bit == LAST_RX_BIT) rx_state_d = RX_STOP;
          else                       rx_bit_d   = rx_bit + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt - 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == '0) begin
          if (rx_s) begin
            // Assigned after the rd clear so a completing byte wins.
            rx_data_d  = rx_sh;
            valid_d    = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_FERR;
          end
        end else begin
          rx_cnt_d = rx_cnt - 1'b1;
        end
      end
      RX_FERR: begin
        if (rx_s) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      valid    <= 1'b0;
    end else begin
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_bit   <= rx_bit_d;
      rx_sh    <= rx_sh_d;
      rx_data  <= rx_data_d;
      valid    <= valid_d;
    end
  end

  // ---------------- transmitter ----------------
  tx_state_t             tx_state, tx_state_d;
  cnt_t                  tx_cnt, tx_cnt_d;
  logic [3:0]            tx_bit, tx_bit_d;
  logic [FRAME_BITS-1:0] tx_frame, tx_frame_d;
  logic                  tx_d, busy_d;

  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_bit_d   = tx_bit;
    tx_frame_d = tx_frame;
    tx_d       = tx;
    busy_d     = busy;

    unique case (tx_state)
      TX_IDLE: begin
        if (wr) begin
          tx_state_d = TX_SEND;
          tx_frame_d = {1'b1, tx_data, 1'b0};
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          tx_cnt_d   = CNT_FULL;
          tx_bit_d   = '0;
        end
      end
      TX_SEND: begin
        if (tx_cnt == '0) begin
          tx_cnt_d = CNT_FULL;
          if (tx_bit == LAST_TX_BIT) begin
            tx_state_d = TX_IDLE;
            tx_d       = 1'b1;
            busy_d     = 1'b0;
          end else begin
            // Frame shifts right; bit 1 is the next bit to drive.
            tx_frame_d = {1'b1, tx_frame[FRAME_BITS-1:1]};
            tx_d       = tx_frame[1];
            tx_bit_d   = tx_bit + 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt - 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_frame <= '1;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_bit   <= tx_bit_d;
      tx_frame <= tx_frame_d;
      tx       <= tx_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_b_uart.sv
// Directed bench for b_uart at 12 MHz / 1 Mbaud (12 clocks per bit).
module tb_b_uart;

  localparam int CPB = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       rx_pin;
  logic       tx;
  logic       rd = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       valid;
  logic       busy;
  logic [7:0] rx_data;

  int n_cmp = 0;
  int n_err = 0;

  assign rx_pin = loop_en ? tx : rx_drv;

  always #5 clk = ~clk;

  b_uart #(.CLK_HZ(12000000), .BAUD(1000000)) dut (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx_pin),
    .tx      (tx),
    .rd      (rd),
    .wr      (wr),
    .tx_data (tx_data),
    .valid   (valid),
    .busy    (busy),
    .rx_data (rx_data)
  );

  // Advance one clock; inputs change and outputs are read 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called right after the edge that accepted wr; checks every cycle of the frame.
  task automatic check_tx_frame(input logic [7:0] data);
    logic [9:0] frame;
    frame = {1'b1, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int j = 0; j < CPB; j++) begin
        check($sformatf("tx_bit%0d_clk%0d", b, j), tx, frame[b]);
        check($sformatf("busy_bit%0d_clk%0d", b, j), busy, 1'b1);
        tick();
      end
    end
    check("busy_fall_120", busy, 1'b0);
    check("tx_idle_after", tx, 1'b1);
  endtask

  task automatic send_wr(input logic [7:0] data);
    tx_data = data;
    wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  // Drive one 8N1 frame on rx; valid_at = cycles from start edge to first valid=1.
  task automatic send_frame(input logic [7:0] data, input logic stop, output int valid_at);
    logic [9:0] frame;
    int cyc;
    frame = {stop, data, 1'b0};
    cyc = 0;
    valid_at = -1;
    for (int b = 0; b < 10; b++) begin
      rx_drv = frame[b];
      for (int j = 0; j < CPB; j++) begin
        tick();
        cyc++;
        if (valid && valid_at < 0) valid_at = cyc;
      end
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    int va;

    // 1: reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    repeat (4) tick();

    // 2: transmit 0xA5, then wr right as busy reads low is accepted
    send_wr(8'hA5);
    check_tx_frame(8'hA5);
    send_wr(8'h5A);
    check("wr_at_busy_fall_busy", busy, 1'b1);
    check("wr_at_busy_fall_tx", tx, 1'b0);
    repeat (130) tick();
    check("second_frame_done", busy, 1'b0);

    // 3: receive 0x3C
    send_frame(8'h3C, 1'b1, va);
    check("rx3c_latency_ok", (va >= 114 && va <= 120), 1'b1);
    check("rx3c_valid", valid, 1'b1);
    check("rx3c_data", rx_data, 8'h3C);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("rd_clears_valid", valid, 1'b0);
    check("rd_keeps_data", rx_data, 8'h3C);

    // 4: loopback, second wr while busy is ignored
    loop_en = 1'b1;
    repeat (3) tick();
    send_wr(8'h55);
    repeat (29) tick();
    send_wr(8'hFF);
    check("wr_while_busy_busy", busy, 1'b1);
    repeat (110) tick();
    check("loop_busy_done", busy, 1'b0);
    check("loop_no_second_frame", tx, 1'b1);
    check("loop_valid", valid, 1'b1);
    check("loop_data", rx_data, 8'h55);
    repeat (20) tick();
    check("loop_still_idle", tx, 1'b1);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    loop_en = 1'b0;
    check("loop_rd_clear", valid, 1'b0);
    repeat (5) tick();

    // 5a: short glitch is not a start bit
    rx_drv = 1'b0;
    repeat (3) tick();
    rx_drv = 1'b1;
    repeat (30) tick();
    check("glitch_no_valid", valid, 1'b0);
    check("glitch_data_kept", rx_data, 8'h55);

    // 5b: framing error discards byte
    send_frame(8'h81, 1'b0, va);
    repeat (20) tick();
    check("ferr_no_valid", valid, 1'b0);
    check("ferr_data_kept", rx_data, 8'h55);

    // 5c: overrun, second byte overwrites, valid stays
    send_frame(8'h11, 1'b1, va);
    check("ovr_first_valid", valid, 1'b1);
    check("ovr_first_data", rx_data, 8'h11);
    send_frame(8'h22, 1'b1, va);
    repeat (5) tick();
    check("ovr_valid", valid, 1'b1);
    check("ovr_data", rx_data, 8'h22);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("ovr_rd_clear", valid, 1'b0);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("rd_idle_valid", valid, 1'b0);
    check("rd_idle_data", rx_data, 8'h22);

    // 6: reset mid-transmit, then a clean frame
    send_wr(8'hC3);
    repeat (39) tick();
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rx_data", rx_data, 8'h00);
    repeat (3) tick();
    send_wr(8'h0F);
    check_tx_frame(8'h0F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
